// File: rtl/m3_pkg.sv
// Shared encodings and defaults for the 3-phase gate dead-time stage.
package m3_pkg;

  localparam logic [1:0] CMD_OFF = 2'b00;
  localparam logic [1:0] CMD_LO  = 2'b01;
  localparam logic [1:0] CMD_HI  = 2'b10;
  localparam logic [1:0] CMD_BAD = 2'b11;

  typedef enum logic [1:0] {
    DEAD,
    IDLE,
    H_ON,
    L_ON
  } phase_st_e;

  // 1 us at 50 MHz
  localparam int DEAD_CYC_DEF = 50;

endpackage

// File: rtl/m3_deadtime_phase.sv
// One phase: gate FSM with dead-time counter and sticky illegal-command fault.
// Gate enables are registered from the next state, so a command sampled at edge t shows at t+1.
module m3_deadtime_phase
  import m3_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF,
  parameter int CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       kill_i,
  input  logic       fault_clr_i,
  input  logic [1:0] cmd_i,
  output logic       h_o,
  output logic       l_o,
  output logic       fault_o,
  output logic       dead_busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYC - 1);

  phase_st_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             h_q, l_q;
  logic             want_hi, want_lo;

  // A latched fault blocks every turn-on; the pre-update value is used so a clear takes effect next cycle.
  assign want_hi = (cmd_i == CMD_HI) && !fault_q;
  assign want_lo = (cmd_i == CMD_LO) && !fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = (fault_q && !fault_clr_i) || (cmd_i == CMD_BAD);
    if (kill_i) begin
      state_d = DEAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DEAD: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (want_hi)      state_d = H_ON;
            else if (want_lo) state_d = L_ON;
            else              state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        IDLE: begin
          if (want_hi)      state_d = H_ON;
          else if (want_lo) state_d = L_ON;
        end
        H_ON: begin
          if (cmd_i != CMD_HI) begin
            state_d = DEAD;
            cnt_d   = '0;
          end
        end
        L_ON: begin
          if (cmd_i != CMD_LO) begin
            state_d = DEAD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = DEAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      h_q     <= (state_d == H_ON);
      l_q     <= (state_d == L_ON);
    end
  end

  assign h_o         = h_q;
  assign l_o         = l_q;
  assign fault_o     = fault_q;
  assign dead_busy_o = (state_q == DEAD);

endmodule

// File: rtl/m3_gate_deadtime.sv
// Six-pin gate driver: three dead-time phases, global kill fan-out and low-side polarity.
// anyOn reports logical gate activity regardless of pin polarity.
module m3_gate_deadtime
  import m3_pkg::*;
#(
  parameter int DEAD_CYC  = DEAD_CYC_DEF,
  parameter int CNT_W     = 8,
  parameter int L_ACT_LOW = 0
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic [1:0] cmdA,
  input  logic [1:0] cmdB,
  input  logic [1:0] cmdC,
  input  logic       kill,
  input  logic       faultClr,
  output logic       aH,
  output logic       aL,
  output logic       bH,
  output logic       bL,
  output logic       cH,
  output logic       cL,
  output logic [2:0] fault,
  output logic [2:0] deadBusy,
  output logic       anyOn
);

  localparam logic L_INV = (L_ACT_LOW != 0);

  logic [5:0] cmd_all;
  logic [2:0] h_on, l_on;

  assign cmd_all = {cmdC, cmdB, cmdA};

  for (genvar p = 0; p < 3; p++) begin : g_phase
    m3_deadtime_phase #(
      .DEAD_CYC(DEAD_CYC),
      .CNT_W   (CNT_W)
    ) u_phase (
      .clk_i      (clk50mhz),
      .reset_i    (reset),
      .kill_i     (kill),
      .fault_clr_i(faultClr),
      .cmd_i      (cmd_all[2*p +: 2]),
      .h_o        (h_on[p]),
      .l_o        (l_on[p]),
      .fault_o    (fault[p]),
      .dead_busy_o(deadBusy[p])
    );
  end

  assign aH = h_on[0];
  assign bH = h_on[1];
  assign cH = h_on[2];
  assign aL = l_on[0] ^ L_INV;
  assign bL = l_on[1] ^ L_INV;
  assign cL = l_on[2] ^ L_INV;

  assign anyOn = |{h_on, l_on};

endmodule
